// File: rtl/pacote_regs.sv
// Shared widths, register-file constants and source encodings for the writeback port arbiter.
package pacote_regs;

  localparam int unsigned LARGURA_DADO = 32;
  localparam int unsigned LARGURA_END  = 5;
  localparam int unsigned NUM_REGS     = 2 ** LARGURA_END;
  localparam logic [LARGURA_END-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    FONTE_ALU = 1'b0,
    FONTE_MEM = 1'b1
  } fonte_e;

endpackage

// File: rtl/slot_escrita.sv
// One-entry holding register for a pending register write, with valid/ready handshake.
module slot_escrita #(
  parameter int unsigned LARGURA_DADO = pacote_regs::LARGURA_DADO,
  parameter int unsigned LARGURA_END  = pacote_regs::LARGURA_END
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    oferta,
  input  logic [LARGURA_END-1:0]  endereco_in,
  input  logic [LARGURA_DADO-1:0] dado_in,
  input  logic                    concede,
  output logic                    pronto,
  output logic                    ocupado,
  output logic [LARGURA_END-1:0]  endereco,
  output logic [LARGURA_DADO-1:0] dado
);
  import pacote_regs::*;

  logic                    ocupado_q, ocupado_d;
  logic [LARGURA_END-1:0]  endereco_q, endereco_d;
  logic [LARGURA_DADO-1:0] dado_q, dado_d;
  logic                    carrega;

  // Writes to x0 complete the handshake but never occupy the slot.
  always_comb begin
    pronto     = ~ocupado_q | concede;
    carrega    = oferta & pronto & (endereco_in != LARGURA_END'(REG_ZERO));
    ocupado_d  = ocupado_q;
    endereco_d = endereco_q;
    dado_d     = dado_q;
    if (carrega) begin
      ocupado_d  = 1'b1;
      endereco_d = endereco_in;
      dado_d     = dado_in;
    end else if (concede) begin
      ocupado_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ocupado_q  <= 1'b0;
      endereco_q <= '0;
      dado_q     <= '0;
    end else begin
      ocupado_q  <= ocupado_d;
      endereco_q <= endereco_d;
      dado_q     <= dado_d;
    end
  end

  assign ocupado  = ocupado_q;
  assign endereco = endereco_q;
  assign dado     = dado_q;

endmodule

// File: rtl/arbitro_escrita_regs.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback,
// with a pending-write mask for hazard detection.
module arbitro_escrita_regs #(
  parameter int unsigned LARGURA_DADO = pacote_regs::LARGURA_DADO,
  parameter int unsigned LARGURA_END  = pacote_regs::LARGURA_END
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req0_valido,
  output logic                         req0_pronto,
  input  logic [LARGURA_END-1:0]       req0_endereco,
  input  logic [LARGURA_DADO-1:0]      req0_dado,
  input  logic                         req1_valido,
  output logic                         req1_pronto,
  input  logic [LARGURA_END-1:0]       req1_endereco,
  input  logic [LARGURA_DADO-1:0]      req1_dado,
  output logic                         reg_escrita,
  output logic [LARGURA_END-1:0]       endereco_regd,
  output logic [LARGURA_DADO-1:0]      dado_escrita,
  output logic [(2**LARGURA_END)-1:0]  pendente
);
  import pacote_regs::*;

  logic                    ocupado0, ocupado1;
  logic [LARGURA_END-1:0]  endereco0, endereco1;
  logic [LARGURA_DADO-1:0] dado0, dado1;
  logic                    concede0, concede1;

  fonte_e                  ultimo_q, ultimo_d;
  logic                    reg_escrita_q, reg_escrita_d;
  logic [LARGURA_END-1:0]  endereco_q, endereco_d;
  logic [LARGURA_DADO-1:0] dado_q, dado_d;

  slot_escrita #(
    .LARGURA_DADO (LARGURA_DADO),
    .LARGURA_END  (LARGURA_END)
  ) u_slot0 (
    .clock       (clock),
    .reset_n     (reset_n),
    .oferta      (req0_valido),
    .endereco_in (req0_endereco),
    .dado_in     (req0_dado),
    .concede     (concede0),
    .pronto      (req0_pronto),
    .ocupado     (ocupado0),
    .endereco    (endereco0),
    .dado        (dado0)
  );

  slot_escrita #(
    .LARGURA_DADO (LARGURA_DADO),
    .LARGURA_END  (LARGURA_END)
  ) u_slot1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .oferta      (req1_valido),
    .endereco_in (req1_endereco),
    .dado_in     (req1_dado),
    .concede     (concede1),
    .pronto      (req1_pronto),
    .ocupado     (ocupado1),
    .endereco    (endereco1),
    .dado        (dado1)
  );

  // On a tie the source that did not win last time is granted.
  always_comb begin
    concede0      = ocupado0 & (~ocupado1 | (ultimo_q == FONTE_MEM));
    concede1      = ocupado1 & (~ocupado0 | (ultimo_q == FONTE_ALU));
    ultimo_d      = ultimo_q;
    reg_escrita_d = 1'b0;
    endereco_d    = endereco_q;
    dado_d        = dado_q;
    if (concede0) begin
      ultimo_d      = FONTE_ALU;
      reg_escrita_d = 1'b1;
      endereco_d    = endereco0;
      dado_d        = dado0;
    end else if (concede1) begin
      ultimo_d      = FONTE_MEM;
      reg_escrita_d = 1'b1;
      endereco_d    = endereco1;
      dado_d        = dado1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ultimo_q      <= FONTE_MEM;
      reg_escrita_q <= 1'b0;
      endereco_q    <= '0;
      dado_q        <= '0;
    end else begin
      ultimo_q      <= ultimo_d;
      reg_escrita_q <= reg_escrita_d;
      endereco_q    <= endereco_d;
      dado_q        <= dado_d;
    end
  end

  always_comb begin
    pendente = '0;
    if (ocupado0)      pendente[endereco0]  = 1'b1;
    if (ocupado1)      pendente[endereco1]  = 1'b1;
    if (reg_escrita_q) pendente[endereco_q] = 1'b1;
    pendente[0] = 1'b0;
  end

  assign reg_escrita   = reg_escrita_q;
  assign endereco_regd = endereco_q;
  assign dado_escrita  = dado_q;

endmodule
